// File: rtl/ex_wb_skid_buffer_pkg.sv
// ex_wb_skid_buffer_pkg
//   Shared constants and the state encoding for the execute->writeback buffer.
//   Payload layout inside the 40-bit registers, MSB first:
//     [39:8] result, [7:5] dreg, [4:1] flags, [0] we
package ex_wb_skid_buffer_pkg;

   localparam int EXWB_DATA_W    = 32;
   localparam int EXWB_DREG_W    = 3;
   localparam int EXWB_FLAG_W    = 4;
   localparam int EXWB_PAYLOAD_W = EXWB_DATA_W + EXWB_DREG_W + EXWB_FLAG_W + 1;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EXWB_EMPTY = 2'd0,
      EXWB_ONE   = 2'd1,
      EXWB_FULL  = 2'd2
   } exwb_state_e;

endpackage

// File: rtl/reg40_en.sv
// reg40_en
//   40-bit register with load enable and asynchronous active-high clear.
//   Ports:
//     clk_i  : clock, rising edge
//     clr_i  : asynchronous clear to zero, active high
//     en_i   : load d_i on the next rising edge
//     d_i    : next value
//     q_o    : registered value
module reg40_en
   import ex_wb_skid_buffer_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      clr_i,
   input  logic                      en_i,
   input  logic [EXWB_PAYLOAD_W-1:0] d_i,
   output logic [EXWB_PAYLOAD_W-1:0] q_o
);

   logic [EXWB_PAYLOAD_W-1:0] data_q;

   always_ff @(posedge clk_i or posedge clr_i) begin
      if (clr_i) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/ex_wb_skid_buffer.sv
// ex_wb_skid_buffer
//   Two-entry valid/ready buffer between execute and writeback. Holds the ALU
//   result with its destination register, flags and write enable until
//   writeback accepts it. in_ready depends on the state register only, so no
//   combinational path runs from out_ready back to in_ready.
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1 on that side; the sender keeps payload stable while valid=1 and
//   ready=0, and payload is don't-care while valid=0.
//   Ports:
//     clk, reset (async, active high), flush (sync discard of all entries)
//     in_valid/in_ready + in_result/in_dreg/in_flags/in_we   : from execute
//     out_valid/out_ready + out_result/out_dreg/out_flags/out_we : to writeback
//     occupancy : entries held (0..2), equal to the FSM state encoding
module ex_wb_skid_buffer
   import ex_wb_skid_buffer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DREG_W = 3,
   parameter int FLAG_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [DREG_W-1:0] in_dreg,
   input  logic [FLAG_W-1:0] in_flags,
   input  logic              in_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [DREG_W-1:0] out_dreg,
   output logic [FLAG_W-1:0] out_flags,
   output logic              out_we,
   output logic [1:0]        occupancy
);

   exwb_state_e state_q, state_d;

   logic                      push, pop;
   logic                      head_en, skid_en, head_from_skid;
   logic [EXWB_PAYLOAD_W-1:0] in_payload, head_d, head_q, skid_q;

   assign in_ready  = (state_q != EXWB_FULL);
   assign out_valid = (state_q != EXWB_EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign in_payload = {in_result, in_dreg, in_flags, in_we};

   // Head loads either the incoming result or, when draining FULL, the skid
   // entry. Wide result field and the 8 side bits are muxed separately.
   assign head_d[EXWB_PAYLOAD_W-1:8] = head_from_skid ? skid_q[EXWB_PAYLOAD_W-1:8]
                                                      : in_payload[EXWB_PAYLOAD_W-1:8];
   assign head_d[7:0]                = head_from_skid ? skid_q[7:0] : in_payload[7:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EXWB_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      head_en        = 1'b0;
      skid_en        = 1'b0;
      head_from_skid = 1'b0;
      if (flush) begin
         // Data registers keep stale contents; they are invalid once EMPTY.
         state_d = EXWB_EMPTY;
      end else begin
         case (state_q)
            EXWB_EMPTY: begin
               if (push) begin
                  state_d = EXWB_ONE;
                  head_en = 1'b1;
               end
            end
            EXWB_ONE: begin
               if (push && pop) begin
                  head_en = 1'b1;
               end else if (push) begin
                  state_d = EXWB_FULL;
                  skid_en = 1'b1;
               end else if (pop) begin
                  state_d = EXWB_EMPTY;
               end
            end
            EXWB_FULL: begin
               if (pop) begin
                  state_d        = EXWB_ONE;
                  head_en        = 1'b1;
                  head_from_skid = 1'b1;
               end
            end
            default: state_d = EXWB_EMPTY;
         endcase
      end
   end

   reg40_en u_head (
      .clk_i (clk),
      .clr_i (reset),
      .en_i  (head_en),
      .d_i   (head_d),
      .q_o   (head_q)
   );

   reg40_en u_skid (
      .clk_i (clk),
      .clr_i (reset),
      .en_i  (skid_en),
      .d_i   (in_payload),
      .q_o   (skid_q)
   );

   assign out_result = head_q[EXWB_PAYLOAD_W-1:8];
   assign out_dreg   = head_q[7:5];
   assign out_flags  = head_q[4:1];
   assign out_we     = head_q[0];
   assign occupancy  = state_q;

endmodule

// File: tb/tb_ex_wb_skid_buffer.sv
module tb_ex_wb_skid_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [2:0]  in_dreg;
  logic [3:0]  in_flags;
  logic        in_we;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_dreg;
  logic [3:0]  out_flags;
  logic        out_we;
  logic [1:0]  occupancy;

  int vectors = 0;
  int miscompares = 0;
  logic [39:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  ex_wb_skid_buffer #(.DATA_W(32), .DREG_W(3), .FLAG_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_dreg    (in_dreg),
    .in_flags   (in_flags),
    .in_we      (in_we),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dreg   (out_dreg),
    .out_flags  (out_flags),
    .out_we     (out_we),
    .occupancy  (occupancy)
  );

  // driver tasks
  task automatic drive_in(input logic v, input logic [31:0] r, input logic [2:0] d,
                          input logic [3:0] f, input logic we);
    in_valid  = v;
    in_result = r;
    in_dreg   = d;
    in_flags  = f;
    in_we     = we;
  endtask

  // One clock: at the negedge the scoreboard accounts for the handshakes that
  // the coming edge will perform, then returns #1 after the rising edge.
  task automatic cycle();
    logic [39:0] exp;
    @(negedge clk);
    vectors++;
    if (occupancy !== 2'(exp_q.size())) begin
      miscompares++;
      $display("FAIL occupancy_model: got %0d expected %0d", occupancy, exp_q.size());
    end
    if (flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_pop: unexpected output %h, queue empty", out_result);
        end else begin
          exp = exp_q.pop_front();
          if ({out_result, out_dreg, out_flags, out_we} !== exp) begin
            miscompares++;
            $display("FAIL sb_payload: got %h expected %h",
                     {out_result, out_dreg, out_flags, out_we}, exp);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_result, in_dreg, in_flags, in_we});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic ov, input logic ir,
                             input logic [1:0] occ);
    vectors++;
    if (out_valid !== ov || in_ready !== ir || occupancy !== occ) begin
      miscompares++;
      $display("FAIL %s: out_valid/in_ready/occupancy got %b/%b/%0d expected %b/%b/%0d",
               name, out_valid, in_ready, occupancy, ov, ir, occ);
    end
  endtask

  task automatic check_out(input string name, input logic [31:0] r, input logic [2:0] d);
    vectors++;
    if (out_result !== r || out_dreg !== d) begin
      miscompares++;
      $display("FAIL %s: out_result/out_dreg got %h/%0d expected %h/%0d",
               name, out_result, out_dreg, r, d);
    end
  endtask

  task automatic drain();
    drive_in(1'b0, 32'h0, 3'd0, 4'd0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check_state("drain_empty", 1'b0, 1'b1, 2'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive_in(1'b0, 32'h0, 3'd0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_state("reset_init", 1'b0, 1'b1, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    // fill to FULL, then reset between edges
    drive_in(1'b1, 32'h5555_0001, 3'd1, 4'hF, 1'b1);
    cycle();
    drive_in(1'b1, 32'h5555_0002, 3'd2, 4'hF, 1'b1);
    cycle();
    check_state("reset_prefull", 1'b1, 1'b0, 2'd2);
    #2;
    reset = 1'b1;
    #1;
    check_state("reset_async", 1'b0, 1'b1, 2'd0);
    vectors++;
    if ({out_result, out_dreg, out_flags, out_we} !== 40'h0) begin
      miscompares++;
      $display("FAIL reset_payload: got %h expected 0", {out_result, out_dreg, out_flags, out_we});
    end
    exp_q.delete();
    drive_in(1'b0, 32'h0, 3'd0, 4'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("reset_release", 1'b0, 1'b1, 2'd0);
  endtask

  task automatic test_streaming();
    logic [31:0] vals[3];
    vals[0] = 32'h1111_1111;
    vals[1] = 32'h2222_2222;
    vals[2] = 32'h3333_3333;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, vals[i], 3'(i + 1), 4'(i), 1'b1);
      cycle();
      check_out("stream_data", vals[i], 3'(i + 1));
      check_state("stream_state", 1'b1, 1'b1, 2'd1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_in(1'b1, 32'hAAAA_0001, 3'd3, 4'h2, 1'b1);
    cycle();
    drive_in(1'b1, 32'hAAAA_0002, 3'd5, 4'h4, 1'b0);
    cycle();
    drive_in(1'b0, 32'hFFFF_FFFF, 3'd7, 4'hF, 1'b1);
    check_state("bp_full", 1'b1, 1'b0, 2'd2);
    check_out("bp_hold0", 32'hAAAA_0001, 3'd3);
    cycle();
    check_out("bp_hold1", 32'hAAAA_0001, 3'd3);
    out_ready = 1'b1;
    cycle();
    check_out("bp_second", 32'hAAAA_0002, 3'd5);
    check_state("bp_one", 1'b1, 1'b1, 2'd1);
    cycle();
    check_state("bp_empty", 1'b0, 1'b1, 2'd0);
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    drive_in(1'b1, 32'h0000_BEEF, 3'd2, 4'h1, 1'b1);
    cycle();
    check_out("pp_head", 32'h0000_BEEF, 3'd2);
    drive_in(1'b1, 32'hCAFE_F00D, 3'd6, 4'h8, 1'b1);
    out_ready = 1'b1;
    cycle();
    check_out("pp_replace", 32'hCAFE_F00D, 3'd6);
    check_state("pp_state", 1'b1, 1'b1, 2'd1);
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_in(1'b1, 32'h0F0F_0001, 3'd1, 4'h0, 1'b1);
    cycle();
    drive_in(1'b1, 32'h0F0F_0002, 3'd2, 4'h0, 1'b1);
    cycle();
    check_state("flush_prefull", 1'b1, 1'b0, 2'd2);
    flush = 1'b1;
    out_ready = 1'b1;
    drive_in(1'b1, 32'hDEAD_DEAD, 3'd7, 4'hF, 1'b1);
    cycle();
    check_state("flush_full", 1'b0, 1'b1, 2'd0);
    // flush in ONE with a simultaneous push: push is discarded too
    flush = 1'b0;
    drive_in(1'b1, 32'h0F0F_0003, 3'd3, 4'h0, 1'b1);
    cycle();
    check_state("flush_preone", 1'b1, 1'b1, 2'd1);
    flush = 1'b1;
    drive_in(1'b1, 32'hDEAD_BEEF, 3'd4, 4'hF, 1'b1);
    cycle();
    flush = 1'b0;
    check_state("flush_one", 1'b0, 1'b1, 2'd0);
    drive_in(1'b0, 32'h0, 3'd0, 4'd0, 1'b0);
    cycle();
    check_state("flush_nofresh", 1'b0, 1'b1, 2'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      drive_in(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 3) != 0 ? ($urandom_range(0, 1)) : 1);
      flush = 1'b0;
      cycle();
      vectors++;
      if (in_ready && occupancy == 2'd2) begin
        miscompares++;
        $display("FAIL rand_ready_full: in_ready=%b occupancy=%0d expected in_ready=0", in_ready, occupancy);
      end
    end
    drain();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_leftover: %0d entries never delivered, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_push_pop();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
